decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
// - Instruction-decode stage of the 5-stage RV32I pipeline. Sits between the IF/ID register and the execute stage.
// - Drives the register-file read addresses and decodes control and immediates.
// - Captures register-file read data, control and operand metadata into the ID/EX pipeline register.
// - Supports stall (hold) and flush (bubble) from the hazard unit.
// PARAMETERS
// - XLEN       32  datapath width
// - REG_AW     5   register address width
// - NOP_INSTR  32'h0000_0013  instruction decoded while valid_d=0 (addi x0,x0,0)
// PORTS
// - clk           in   1      rising-edge clock
// - rst           in   1      asynchronous, active-high reset
// - instr_d       in   32     instruction from IF/ID
// - pc_d          in   32     PC of instr_d
// - pc_plus4_d    in   32     pc_d+4
// - valid_d       in   1      instr_d is a real instruction
// - stall_e       in   1      hold ID/EX contents
// - flush_e       in   1      load bubble into ID/EX
// - rd1_d         in   32     register-file read data, port 1
// - rd2_d         in   32     register-file read data, port 2
// - a1_d          out  5      register-file read address 1 = instr_d[19:15] (combinational)
// - a2_d          out  5      register-file read address 2 = instr_d[24:20] (combinational)
// - rd1_e, rd2_e  out  32     registered operands
// - rs1_e, rs2_e, rd_e  out 5  registered register indices (for forwarding)
// - imm_ext_e     out  32     registered sign-extended immediate
// - pc_e, pc_plus4_e    out 32 registered PCs
// - reg_write_e, mem_write_e, alu_src_e, branch_e, jump_e  out 1  registered control
// - result_src_e  out  2      00 ALU, 01 memory, 10 pc+4
// - alu_control_e out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
// - valid_e, illegal_e  out 1  registered valid / illegal-opcode flag
// BEHAVIOUR
// - Reset (async, rst=1): every registered output = 0. a1_d/a2_d remain combinational.
// - Latency: one cycle. Values decoded in cycle N appear on *_e after edge N+1.
// - Edge priority: rst > flush_e > stall_e > load.
//   - flush_e=1 (also with stall_e=1): all outputs cleared to 0, valid_e=0.
//   - stall_e=1 only: all *_e hold their values.
// - Supported opcodes and control (all other control bits 0):
//   - 0110011 R: reg_write; ALU from funct3/funct7[5]. add/sub, and, or, slt.
//   - 0010011 I-ALU: reg_write, alu_src, I-imm. addi, andi, ori, slti. funct7 is ignored.
//   - 0000011 lw: reg_write, alu_src, result_src=01, add, I-imm.
//   - 0100011 sw: mem_write, alu_src, add, S-imm.
//   - 1100011 beq: branch, sub, B-imm.
//   - 1101111 jal: reg_write, jump, result_src=10, J-imm.
// - Unsupported opcode or funct3 (valid_d=1): all control 0, illegal_e=1, valid_e=1.
// - valid_d=0: decode NOP_INSTR; valid_e=0, illegal_e=0.
// - Immediates are sign-extended from instr[31]:
//   - I: [31:20]
//   - S: {[31:25],[11:7]}
//   - B: {[31],[7],[30:25],[11:8],0}
//   - J: {[31],[19:12],[20],[30:21],0}
//   - R-type: imm_ext_e = 0.
// - rd=0: reg_write_e forced to 0 (writes to x0 are suppressed at the source).
// - rs1_e/rs2_e are captured for every format. Consumers qualify them by opcode.
// - rst asserted mid-stall or mid-flush: outputs clear immediately. The first edge after release loads normally.
// STRUCTURE
// - Shared package rv32i_pkg holds:
//   - opcode localparams (OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL)
//   - ALU_ADD/SUB/AND/OR/SLT codes
//   - RES_ALU/RES_MEM/RES_PC4 codes
//   - IMM_I/S/B/J selectors
// - Sub-module control_decoder: combinational; instr -> control bits, imm_src, illegal.
// - decode_stage contains the immediate extender and the ID/EX register.
// TESTING
// - Reset: pulse rst while loaded with lw -> all *_e = 0 asynchronously, before the next clk edge.
// - Decode lw: instr 32'h0082_A303 (lw x6,8(x5)) -> a1_d=5; next edge gives:
//   rd_e=6, imm_ext_e=8, alu_src_e=1, result_src_e=01, reg_write_e=1, valid_e=1.
// - Negative immediates:
//   - beq x1,x2,-4 (32'hFE20_8EE3) -> imm_ext_e=32'hFFFF_FFFC, branch_e=1, alu_control_e=001.
//   - jal x1,-8 -> imm_ext_e=32'hFFFF_FFF8, result_src_e=10.
// - Stall then flush: load add; stall_e=1 for 3 cycles -> *_e unchanged.
//   - Then flush_e=1 together with stall_e=1 -> valid_e=0, all control 0.
// - Illegal and x0: opcode 7'b1111111 -> illegal_e=1, reg_write_e=0, mem_write_e=0.
//   - add x0,x1,x2 -> reg_write_e=0.
// - Bubble input: valid_d=0 with garbage instr_d -> valid_e=0, illegal_e=0, reg_write_e=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU and result-mux codes, immediate selectors.
package rv32i_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // IMM_NONE yields a zero immediate (R-type and illegal encodings).
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_src_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  // Only add/sub, slt, or, and exist in this core's ALU.
  function automatic logic alu_funct3_ok(input logic [2:0] funct3);
    return (funct3 == 3'b000) || (funct3 == 3'b010) ||
           (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // sub_sel is only honoured for funct3=000 (R-type sub).
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub_sel);
    case (funct3)
      3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational main decoder: opcode/funct fields -> control bits, immediate format, illegal flag.
module control_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_t      ctrl,
  output imm_src_t   imm_src,
  output logic       illegal
);

  // Decode opcode into control; anything unrecognised leaves control cleared and flags illegal.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    ctrl    = '0;
    imm_src = IMM_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (alu_funct3_ok(funct3)) begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_control = alu_from_funct3(funct3, funct7_5);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_I: begin
        if (alu_funct3_ok(funct3)) begin
          ctrl.reg_write   = 1'b1;
          ctrl.alu_src     = 1'b1;
          ctrl.alu_control = alu_from_funct3(funct3, 1'b0);
          imm_src          = IMM_I;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LW: begin
        if (funct3 == 3'b010) begin
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.result_src = RES_MEM;
          imm_src         = IMM_I;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_SW: begin
        if (funct3 == 3'b010) begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          imm_src        = IMM_S;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_BEQ: begin
        if (funct3 == 3'b000) begin
          ctrl.branch      = 1'b1;
          ctrl.alu_control = ALU_SUB;
          imm_src          = IMM_B;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, control/immediate decode and the ID/EX register.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          REG_AW    = 5,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic              valid_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  output logic [REG_AW-1:0] a1_d,
  output logic [REG_AW-1:0] a2_d,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic              branch_e,
  output logic              jump_e,
  output logic [1:0]        result_src_e,
  output logic [2:0]        alu_control_e,
  output logic              valid_e,
  output logic              illegal_e
);

  logic [31:0]     instr;
  ctrl_t           ctrl;
  imm_src_t        imm_src;
  logic            illegal;
  logic [XLEN-1:0] imm_ext;
  logic            reg_write;

  // Register-file addresses come straight from the fetched word, bubble or not.
  assign a1_d = instr_d[19:15];
  assign a2_d = instr_d[24:20];

  // A bubble decodes as addi x0,x0,0 so it can never write state downstream.
  assign instr = valid_d ? instr_d : NOP_INSTR;

  control_decoder u_control_decoder (
    .opcode   (instr[6:0]),
    .funct3   (instr[14:12]),
    .funct7_5 (instr[30]),
    .ctrl     (ctrl),
    .imm_src  (imm_src),
    .illegal  (illegal)
  );

  // Writes to x0 are dropped here so forwarding never sees a phantom producer.
  assign reg_write = ctrl.reg_write && (instr[11:7] != 5'd0);

  // Sign-extend the immediate for the selected instruction format.
  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I:   imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // ID/EX register: flush inserts a bubble, stall holds, otherwise load the decoded word.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst || flush_e) begin
      if (rst) begin
        rd1_e <= '0;
      end else begin
        rd1_e <= '0;
      end
      rd2_e         <= '0;
      rs1_e         <= '0;
      rs2_e         <= '0;
      rd_e          <= '0;
      imm_ext_e     <= '0;
      pc_e          <= '0;
      pc_plus4_e    <= '0;
      reg_write_e   <= 1'b0;
      mem_write_e   <= 1'b0;
      alu_src_e     <= 1'b0;
      branch_e      <= 1'b0;
      jump_e        <= 1'b0;
      result_src_e  <= '0;
      alu_control_e <= '0;
      valid_e       <= 1'b0;
      illegal_e     <= 1'b0;
    end else if (!stall_e) begin
      rd1_e         <= rd1_d;
      rd2_e         <= rd2_d;
      rs1_e         <= instr[19:15];
      rs2_e         <= instr[24:20];
      rd_e          <= instr[11:7];
      imm_ext_e     <= imm_ext;
      pc_e          <= pc_d;
      pc_plus4_e    <= pc_plus4_d;
      reg_write_e   <= reg_write;
      mem_write_e   <= ctrl.mem_write;
      alu_src_e     <= ctrl.alu_src;
      branch_e      <= ctrl.branch;
      jump_e        <= ctrl.jump;
      result_src_e  <= ctrl.result_src;
      alu_control_e <= ctrl.alu_control;
      valid_e       <= valid_d;
      illegal_e     <= valid_d && illegal;
    end
  end

endmodule
